// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between bus masters and the round-robin arbiter.
// The shared-bus mux selects on o_gnt_id while o_gnt_valid is high.
interface bus_arbiter_rr_if #(
   parameter int NUM_MASTERS = 4,
   parameter int ID_W        = $clog2(NUM_MASTERS)
) ();

   logic [NUM_MASTERS-1:0] i_req;
   logic [NUM_MASTERS-1:0] i_lock;
   logic                   i_rr_mode;
   logic [NUM_MASTERS-1:0] o_gnt;
   logic [ID_W-1:0]        o_gnt_id;
   logic                   o_gnt_valid;

   modport master (
      output i_req,
      output i_lock,
      output i_rr_mode,
      input  o_gnt,
      input  o_gnt_id,
      input  o_gnt_valid
   );

   modport slave (
      input  i_req,
      input  i_lock,
      input  i_rr_mode,
      output o_gnt,
      output o_gnt_id,
      output o_gnt_valid
   );

endinterface

// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter: registered one-hot grant, fixed or round-robin pick,
// max-hold preemption with per-master lock, direct owner-to-owner handoff.
module bus_arbiter_rr #(
   parameter int  NUM_MASTERS = 4,
   parameter int  MAX_HOLD    = 16,
   localparam int ID_W        = $clog2(NUM_MASTERS)
) (
   input logic             i_clk,
   input logic             i_rst,
   bus_arbiter_rr_if.slave bus
);

   localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] CNT_SAT =
      (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD - 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   logic [0:0]             state_q;
   logic [0:0]             state_d;
   logic [NUM_MASTERS-1:0] gnt_q;
   logic [NUM_MASTERS-1:0] gnt_d;
   logic [ID_W-1:0]        id_q;
   logic [ID_W-1:0]        id_d;
   logic                   valid_q;
   logic                   valid_d;
   logic [ID_W-1:0]        ptr_q;
   logic [ID_W-1:0]        ptr_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;

   logic                   owner_req;
   logic                   owner_lock;
   logic [NUM_MASTERS-1:0] others;
   logic                   expired;
   logic                   preempt;
   logic                   take;
   logic [NUM_MASTERS-1:0] cand;
   logic [ID_W-1:0]        win;

   // Fixed mode scans from 0; round-robin scans from ptr with wrap.
   function automatic logic [ID_W-1:0] pick(
      input logic [NUM_MASTERS-1:0] c,
      input logic                   rr,
      input logic [ID_W-1:0]        p
   );
      logic [ID_W-1:0] r;
      logic            found;
      int              idx;
      r     = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         idx = rr ? ((int'(p) + k) % NUM_MASTERS) : k;
         if (!found && c[idx]) begin
            found = 1'b1;
            r     = ID_W'(idx);
         end
      end
      return r;
   endfunction

   assign owner_req  = |(bus.i_req & gnt_q);
   assign owner_lock = |(bus.i_lock & gnt_q);
   assign others     = bus.i_req & ~gnt_q;
   assign expired    = (MAX_HOLD != 0) && (cnt_q == CNT_SAT);
   assign preempt    = owner_req && expired && !owner_lock && (|others);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      id_d    = id_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      take    = 1'b0;
      cand    = '0;
      win     = '0;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (|bus.i_req) begin
               take = 1'b1;
               cand = bus.i_req;
            end
         end
         ST_GRANT: begin
            unique case (1'b1)
               !owner_req: begin
                  if (|bus.i_req) begin
                     take = 1'b1;
                     cand = bus.i_req;
                  end else begin
                     state_d = ST_IDLE;
                     gnt_d   = '0;
                     valid_d = 1'b0;
                     cnt_d   = '0;
                  end
               end
               preempt: begin
                  take = 1'b1;
                  cand = others;
               end
               (owner_req && !preempt): begin
                  if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
               end
            endcase
         end
      endcase

      // Every new grant restarts the hold count and advances the pointer.
      if (take) begin
         win          = pick(cand, bus.i_rr_mode, ptr_q);
         state_d      = ST_GRANT;
         gnt_d        = '0;
         gnt_d[win]   = 1'b1;
         id_d         = win;
         valid_d      = 1'b1;
         cnt_d        = '0;
         ptr_d        = (win == ID_W'(NUM_MASTERS - 1)) ?
                        '0 : win + ID_W'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         id_q    <= '0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.o_gnt       = gnt_q;
   assign bus.o_gnt_id    = id_q;
   assign bus.o_gnt_valid = valid_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Randomised bench for bus_arbiter_rr against an owner/held-cycles model,
// plus directed literal checks of the main grant scenarios.
module tb_bus_arbiter_rr;

   localparam int NM    = 4;
   localparam int MAXH  = 4;
   localparam int BOUND = (NM - 1) * MAXH + NM;

   typedef struct {
      int owner;
      int held;
      int ptr;
   } mstate_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   chk_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   mstate_t   m = '{owner: -1, held: 0, ptr: 0};
   logic [3:0] req_edge = '0;

   bus_arbiter_rr_if #(.NUM_MASTERS(NM)) bus ();

   bus_arbiter_rr #(
      .NUM_MASTERS(NM),
      .MAX_HOLD   (MAXH)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic int model_pick(logic [3:0] c, logic rr, int p);
      for (int k = 0; k < NM; k++) begin
         int idx;
         idx = rr ? (p + k) % NM : k;
         if (c[idx]) return idx;
      end
      return -1;
   endfunction

   // Owner keeps the bus while requesting, unless it has held MAXH
   // cycles, is unlocked and someone else wants the bus.
   function automatic mstate_t model_next(mstate_t s, logic [3:0] req,
                                          logic [3:0] lock, logic rr);
      mstate_t    n;
      logic [3:0] c;
      bit         take;
      int         w;
      n    = s;
      c    = '0;
      take = 0;
      if (s.owner < 0) begin
         if (req != 0) begin take = 1; c = req; end
      end else if (!req[s.owner]) begin
         if (req != 0) begin
            take = 1; c = req;
         end else begin
            n.owner = -1; n.held = 0;
         end
      end else if (s.held >= MAXH && !lock[s.owner] &&
                   (req & ~(4'b0001 << s.owner)) != 0) begin
         take = 1;
         c = req & ~(4'b0001 << s.owner);
      end else begin
         n.held = s.held + 1;
      end
      if (take) begin
         w       = model_pick(c, rr, s.ptr);
         n.owner = w;
         n.held  = 1;
         n.ptr   = (w + 1) % NM;
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m        <= '{owner: -1, held: 0, ptr: 0};
         req_edge <= '0;
      end else begin
         m        <= model_next(m, bus.i_req, bus.i_lock, bus.i_rr_mode);
         req_edge <= bus.i_req;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [3:0] eg;
         eg = (m.owner < 0) ? 4'b0000 : 4'(1 << m.owner);
         checks++;
         if (bus.o_gnt !== eg || bus.o_gnt_valid !== (m.owner >= 0) ||
             (m.owner >= 0 && int'(bus.o_gnt_id) != m.owner)) begin
            errors++;
            $display("FAIL model t=%0t gnt=%b id=%0d v=%b want gnt=%b id=%0d",
                     $time, bus.o_gnt, bus.o_gnt_id, bus.o_gnt_valid,
                     eg, m.owner);
         end
         checks++;
         if ($countones(bus.o_gnt) > 1 ||
             (bus.o_gnt & ~req_edge) != 0) begin
            errors++;
            $display("FAIL onehot_req t=%0t gnt=%b req=%b want one-hot subset",
                     $time, bus.o_gnt, req_edge);
         end
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.i_req  = '0;
      bus.i_lock = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   int         waitc[NM];
   int         worst;

   initial begin
      bus.i_req     = '0;
      bus.i_lock    = '0;
      bus.i_rr_mode = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_gnt", 32'(bus.o_gnt), 32'h0);
      chk("rst_id", 32'(bus.o_gnt_id), 32'h0);
      chk("rst_valid", 32'(bus.o_gnt_valid), 32'h0);
      rst    = 1'b0;
      chk_en = 1'b1;

      // fixed priority from idle
      @(negedge clk);
      bus.i_req = 4'b1010;
      @(negedge clk);
      chk("fix_gnt", 32'(bus.o_gnt), 32'h2);
      chk("fix_id", 32'(bus.o_gnt_id), 32'h1);
      repeat (3) begin
         @(negedge clk);
         chk("fix_hold", 32'(bus.o_gnt), 32'h2);
      end

      // round robin rotation, 4 cycles each, no gaps
      do_reset();
      bus.i_rr_mode = 1'b1;
      bus.i_req     = 4'b1111;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         chk("rr_rot", 32'(bus.o_gnt), 32'(1 << (((c - 1) / 4) % 4)));
      end

      // handoff 2 -> 3, then idle
      do_reset();
      bus.i_req = 4'b0100;
      @(negedge clk);
      chk("ho_own2", 32'(bus.o_gnt), 32'h4);
      bus.i_req = 4'b1100;
      @(negedge clk);
      chk("ho_keep2", 32'(bus.o_gnt), 32'h4);
      bus.i_req = 4'b1000;
      @(negedge clk);
      chk("ho_gnt3", 32'(bus.o_gnt), 32'h8);
      chk("ho_valid", 32'(bus.o_gnt_valid), 32'h1);
      bus.i_req = 4'b0000;
      @(negedge clk);
      chk("ho_idle", 32'(bus.o_gnt), 32'h0);

      // lock blocks preemption, release moves grant at once
      do_reset();
      bus.i_rr_mode = 1'b0;
      bus.i_req     = 4'b0011;
      bus.i_lock    = 4'b0001;
      repeat (10) begin
         @(negedge clk);
         chk("lock_hold", 32'(bus.o_gnt), 32'h1);
      end
      bus.i_lock = 4'b0000;
      @(negedge clk);
      chk("lock_rel", 32'(bus.o_gnt), 32'h2);

      // lone requester never preempted; async reset mid-grant
      do_reset();
      bus.i_req = 4'b1000;
      repeat (20) begin
         @(negedge clk);
         chk("lone_hold", 32'(bus.o_gnt), 32'h8);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_gnt", 32'(bus.o_gnt), 32'h0);
      chk("arst_valid", 32'(bus.o_gnt_valid), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("arst_regnt", 32'(bus.o_gnt), 32'h8);

      // fully random req/lock/mode against the model
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         bus.i_req  = 4'($urandom);
         bus.i_lock = 4'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 15) == 0) bus.i_rr_mode = ~bus.i_rr_mode;
      end

      // RR, no locks, requests held until granted: starvation bound
      do_reset();
      bus.i_rr_mode = 1'b1;
      bus.i_lock    = '0;
      for (int i = 0; i < NM; i++) waitc[i] = 0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         worst = 0;
         for (int i = 0; i < NM; i++) begin
            if (bus.i_req[i] && !bus.o_gnt[i]) waitc[i]++;
            else waitc[i] = 0;
            if (waitc[i] > worst) worst = waitc[i];
         end
         checks++;
         if (worst > BOUND) begin
            errors++;
            $display("FAIL starve t=%0t wait=%0d want<=%0d",
                     $time, worst, BOUND);
         end
         for (int i = 0; i < NM; i++) begin
            if (!bus.i_req[i]) begin
               if ($urandom_range(0, 2) == 0) bus.i_req[i] = 1'b1;
            end else if (bus.o_gnt[i]) begin
               if ($urandom_range(0, 3) == 0) bus.i_req[i] = 1'b0;
            end
         end
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
